// File: rtl/temp_pkg.sv
// temp_pkg: shared types and constants for the temperature hub.
//   hub_state_e   - hub FSM states
//   F_MUL/F_SHIFT/F_OFF - fixed-point Celsius to Fahrenheit constants (9/5 ~= 461/256)
//   F_EXTRA_W     - headroom bits used for the Fahrenheit multiply
//   disp_width()  - width of a display temperature for a given sample width
package temp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StConvert,
        StEmit
    } hub_state_e;

    localparam int unsigned F_MUL     = 461;
    localparam int unsigned F_SHIFT   = 8;
    localparam int unsigned F_OFF     = 32;
    localparam int unsigned F_EXTRA_W = 11;

    // Display values carry two extra bits so Fahrenheit fits for any Celsius input.
    function automatic int unsigned disp_width(input int unsigned data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/temp_avg_buf.sv
// temp_avg_buf: per-channel boxcar averaging store.
// Holds 2^AVG_LOG2 sample slots, a write pointer, a running sum and a "seen" flag per
// channel. Single write port; avg_o is the average that results from writing data_i
// into channel ch_i, valid combinationally in the same cycle as the write.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   wr_en_i    - commit data_i into channel ch_i
//   ch_i       - channel index (out-of-range values fall back to channel 0)
//   data_i     - signed Celsius sample
//   seen_o     - channel ch_i has received at least one sample since reset
//   avg_o      - post-write average for channel ch_i (floor)
module temp_avg_buf
    import temp_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic signed [DATA_W-1:0] data_i,
    output logic                     seen_o,
    output logic signed [DATA_W-1:0] avg_o
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

    logic signed [DATA_W-1:0] slot_q [NUM_CH][DEPTH];
    logic [PTR_W-1:0]         wp_q   [NUM_CH];
    logic signed [SUM_W-1:0]  sum_q  [NUM_CH];
    logic [NUM_CH-1:0]        seen_q;

    logic [CH_W-1:0]          ch_idx;
    logic signed [DATA_W-1:0] oldest;
    logic signed [SUM_W-1:0]  data_ext;
    logic signed [SUM_W-1:0]  sum_d;
    logic [PTR_W-1:0]         wp_next;

    always_comb begin
        ch_idx   = (32'(ch_i) < NUM_CH) ? ch_i : '0;
        seen_o   = seen_q[ch_idx];
        // The write pointer always addresses the oldest slot of the window.
        oldest   = slot_q[ch_idx][wp_q[ch_idx]];
        data_ext = SUM_W'(data_i);
        if (seen_q[ch_idx]) begin
            sum_d = sum_q[ch_idx] + data_ext - SUM_W'(oldest);
        end else begin
            sum_d = data_ext <<< AVG_LOG2;
        end
        avg_o   = DATA_W'(sum_d >>> AVG_LOG2);
        wp_next = (AVG_LOG2 == 0) ? '0 : wp_q[ch_idx] + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    slot_q[c][s] <= '0;
                end
                wp_q[c]  <= '0;
                sum_q[c] <= '0;
            end
            seen_q <= '0;
        end else if (wr_en_i) begin
            sum_q[ch_idx]  <= sum_d;
            seen_q[ch_idx] <= 1'b1;
            if (seen_q[ch_idx]) begin
                slot_q[ch_idx][wp_q[ch_idx]] <= data_i;
                wp_q[ch_idx]                 <= wp_next;
            end else begin
                // First sample primes the whole window so the average starts at the sample.
                for (int s = 0; s < DEPTH; s++) begin
                    slot_q[ch_idx][s] <= data_i;
                end
                wp_q[ch_idx] <= '0;
            end
        end
    end

endmodule

// File: rtl/temp_sense_hub.sv
// temp_sense_hub: multi-channel temperature front end.
// Accepts channel-tagged signed Celsius samples, keeps a per-channel boxcar average and
// min/max of that average, and emits one record per accepted in-range sample in Celsius
// or Fahrenheit (chosen per sample at acceptance). FSM: IDLE -> ACCUM -> CONVERT -> EMIT.
// Optional build macro TEMP_ALARM_EN adds a per-channel over-temperature alarm with
// hysteresis (ports alarm_thresh, alarm).
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   sample_valid/ready/ch/data - sample input handshake
//   unit_sel                   - 0 Celsius, 1 Fahrenheit, sampled at acceptance
//   disp_valid/ready           - display record handshake
//   disp_ch/temp/min/max/unit  - display record fields
//   ch_err                     - sticky: out-of-range channel seen
module temp_sense_hub
    import temp_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned HYST     = 2,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned DISP_W  = disp_width(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic [CH_W-1:0]          sample_ch,
    input  logic [DATA_W-1:0]        sample_data,
    input  logic                     unit_sel,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [CH_W-1:0]          disp_ch,
    output logic [DISP_W-1:0]        disp_temp,
    output logic [DISP_W-1:0]        disp_min,
    output logic [DISP_W-1:0]        disp_max,
    output logic                     disp_unit,
`ifdef TEMP_ALARM_EN
    input  logic [DATA_W-1:0]        alarm_thresh,
    output logic [NUM_CH-1:0]        alarm,
`endif
    output logic                     ch_err
);

    localparam int unsigned MUL_W = DATA_W + F_EXTRA_W;

    hub_state_e state_q, state_d;

    logic [CH_W-1:0]          ch_q;
    logic signed [DATA_W-1:0] data_q;
    logic                     unit_q;
    logic signed [DATA_W-1:0] avg_q;
    logic signed [DATA_W-1:0] min_q [NUM_CH];
    logic signed [DATA_W-1:0] max_q [NUM_CH];

    logic [CH_W-1:0]          disp_ch_q;
    logic [DISP_W-1:0]        disp_temp_q;
    logic [DISP_W-1:0]        disp_min_q;
    logic [DISP_W-1:0]        disp_max_q;
    logic                     disp_unit_q;
    logic                     ch_err_q;

    logic                     ch_ok;
    logic                     accept;
    logic                     buf_wr;
    logic                     buf_seen;
    logic signed [DATA_W-1:0] buf_avg;

    function automatic logic [DISP_W-1:0] to_unit(input logic signed [DATA_W-1:0] c,
                                                  input logic fahr);
        logic signed [MUL_W-1:0] c_ext;
        logic signed [MUL_W-1:0] prod;
        c_ext = MUL_W'(c);
        prod  = ((c_ext * $signed(MUL_W'(F_MUL))) >>> F_SHIFT) + $signed(MUL_W'(F_OFF));
        if (fahr) begin
            return DISP_W'(prod);
        end
        return DISP_W'(c);
    endfunction

    temp_avg_buf #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2),
        .CH_W     (CH_W)
    ) u_avg_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (buf_wr),
        .ch_i    (ch_q),
        .data_i  (data_q),
        .seen_o  (buf_seen),
        .avg_o   (buf_avg)
    );

    always_comb begin
        state_d      = state_q;
        sample_ready = 1'b0;
        disp_valid   = 1'b0;
        buf_wr       = 1'b0;
        ch_ok        = 32'(sample_ch) < NUM_CH;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                sample_ready = 1'b1;
                accept       = sample_valid;
                // Out-of-range samples are consumed here and never reach ACCUM.
                if (sample_valid && ch_ok) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                buf_wr  = 1'b1;
                state_d = StConvert;
            end
            StConvert: begin
                state_d = StEmit;
            end
            StEmit: begin
                disp_valid = 1'b1;
                if (disp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q        <= '0;
            data_q      <= '0;
            unit_q      <= 1'b0;
            avg_q       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                min_q[c] <= '0;
                max_q[c] <= '0;
            end
            disp_ch_q   <= '0;
            disp_temp_q <= '0;
            disp_min_q  <= '0;
            disp_max_q  <= '0;
            disp_unit_q <= 1'b0;
            ch_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                ch_q   <= sample_ch;
                data_q <= sample_data;
                unit_q <= unit_sel;
                if (!ch_ok) begin
                    ch_err_q <= 1'b1;
                end
            end
            if (state_q == StAccum) begin
                avg_q <= buf_avg;
                if (!buf_seen) begin
                    min_q[ch_q] <= buf_avg;
                    max_q[ch_q] <= buf_avg;
                end else begin
                    if (buf_avg < min_q[ch_q]) begin
                        min_q[ch_q] <= buf_avg;
                    end
                    if (buf_avg > max_q[ch_q]) begin
                        max_q[ch_q] <= buf_avg;
                    end
                end
            end
            if (state_q == StConvert) begin
                disp_ch_q   <= ch_q;
                disp_unit_q <= unit_q;
                disp_temp_q <= to_unit(avg_q, unit_q);
                disp_min_q  <= to_unit(min_q[ch_q], unit_q);
                disp_max_q  <= to_unit(max_q[ch_q], unit_q);
            end
        end
    end

`ifdef TEMP_ALARM_EN
    logic [NUM_CH-1:0]        alarm_q;
    logic signed [DISP_W-1:0] thr_hi;
    logic signed [DISP_W-1:0] thr_lo;
    logic signed [DISP_W-1:0] avg_ext;

    // Compare at display width so thresh - HYST cannot wrap.
    always_comb begin
        thr_hi  = DISP_W'($signed(alarm_thresh));
        thr_lo  = thr_hi - $signed(DISP_W'(HYST));
        avg_ext = DISP_W'(buf_avg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= '0;
        end else if (state_q == StAccum) begin
            if (avg_ext > thr_hi) begin
                alarm_q[ch_q] <= 1'b1;
            end else if (avg_ext < thr_lo) begin
                alarm_q[ch_q] <= 1'b0;
            end
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_hyst;
    assign unused_hyst = ^HYST;
`endif

    assign disp_ch   = disp_ch_q;
    assign disp_temp = disp_temp_q;
    assign disp_min  = disp_min_q;
    assign disp_max  = disp_max_q;
    assign disp_unit = disp_unit_q;
    assign ch_err    = ch_err_q;

endmodule
